// File: rtl/seq_div8by4.sv
// -----------------------------------------------------------------------------
// seq_div8by4
//
// Sequential restoring divider: 8-bit unsigned dividend / 4-bit unsigned
// divisor -> 8-bit quotient and 4-bit remainder. It is the inverse companion
// of the 4x4 array multiplier, so dividing an 8-bit product by one factor
// recovers the other. One quotient bit is produced per clock, MSB first,
// behind a start/done handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; only sampled while idle
//   dividend     8-bit unsigned dividend, sampled with start
//   divisor      4-bit unsigned divisor, sampled with start
//   busy         high while iterating (RUN)
//   done         one-cycle pulse; results valid while high
//   quotient     8-bit result, held until the next result is written
//   remainder    4-bit result, held until the next result is written
//   div_by_zero  set with done when the divisor was zero; held like results
//
// Timing: start accepted at edge N -> iterations at edges N+1..N+8, done high
// for the cycle after N+8, back in IDLE after N+9. A zero divisor skips RUN
// and raises done for the cycle after N.
// -----------------------------------------------------------------------------
module seq_div8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  d_q;      // dividend shift register; quotient bits shift in at the LSB
  logic [3:0]  v_q;      // latched divisor
  logic [3:0]  r_q;      // partial remainder
  logic [2:0]  cnt_q;    // iteration counter, 0..7
  logic        busy_q;
  logic        done_q;
  logic [7:0]  quot_q;
  logic [3:0]  rem_q;
  logic        dbz_q;

  // One restoring iteration, computed from the current state.
  logic [4:0]  t_d;
  logic        qbit_d;
  logic [3:0]  r_d;
  logic [7:0]  d_d;

  always_comb begin
    t_d    = {r_q, d_q[7]};
    qbit_d = (t_d >= {1'b0, v_q});
    // The partial remainder is always below the divisor, so the top bit of a
    // 5-bit R is zero after every iteration and only 4 bits are kept. When the
    // subtract happens, T - V < V <= 15, so a 4-bit modular subtract is exact.
    r_d    = qbit_d ? (t_d[3:0] - v_q) : t_d[3:0];
    d_d    = {d_q[6:0], qbit_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= 8'h00;
      v_q     <= 4'h0;
      r_q     <= 4'h0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 8'h00;
      rem_q   <= 4'h0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            d_q   <= dividend;
            v_q   <= divisor;
            r_q   <= 4'h0;
            cnt_q <= 3'd0;
            if (divisor == 4'h0) begin
              // Fast path: no iterations, publish the saturated result now.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              quot_q  <= 8'hFF;
              rem_q   <= 4'h0;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          d_q   <= d_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // Last iteration: results come straight from this step's values.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= d_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
          end
        end

        S_DONE: begin
          // start is ignored here; the next request is taken in IDLE.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8by4.sv
// -----------------------------------------------------------------------------
// tb_seq_div8by4
//
// Directed, self-checking bench for seq_div8by4. Each scenario task drives its
// own stimulus and compares outputs against hand-computed values. Outputs are
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_seq_div8by4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [3:0] divisor = 4'h0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Stimulus helper: issue one request and wait (bounded) for done.
  // lat = number of rising edges from the accepting edge to the done cycle,
  // or -1 if done never came. Operands are scrambled after acceptance.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int busy_cnt,
                         output int overlap, output logic [7:0] q_acc);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    q_acc    = quotient;
    lat      = 1;
    busy_cnt = 0;
    overlap  = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (done && busy) overlap = 1;
    if (!done) lat = -1;
    $display("div %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d",
             a, b, quotient, remainder, div_by_zero, lat);
  endtask

  task automatic test_reset();
    int lat, bc, ov;
    logic [7:0] qa;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++;
    if (quotient !== 8'h00) begin n_fail++; $display("FAIL reset_quotient got %0h want 00", quotient); end
    n_checks++;
    if (remainder !== 4'h0) begin n_fail++; $display("FAIL reset_remainder got %0h want 0", remainder); end
    n_checks++;
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end

    // Produce a non-zero held result, then start another and reset mid-cycle.
    run_div(8'd200, 4'd7, lat, bc, ov, qa);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd143;
    divisor  = 4'd11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %0b want 0", busy); end
    n_checks++;
    if (quotient !== 8'h00) begin n_fail++; $display("FAIL async_reset_quotient got %0h want 00", quotient); end
    n_checks++;
    if (remainder !== 4'h0) begin n_fail++; $display("FAIL async_reset_remainder got %0h want 0", remainder); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done got %0b want 0", done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int va [4] = '{200, 143, 255, 5};
    int vb [4] = '{7, 11, 1, 9};
    int vq [4] = '{28, 13, 255, 0};
    int vr [4] = '{4, 0, 0, 5};
    int lat, bc, ov;
    logic [7:0] qa;
    logic [7:0] prev_q;
    prev_q = 8'h00;  // held value after the aborted run in test_reset
    for (int i = 0; i < 4; i++) begin
      run_div(8'(va[i]), 4'(vb[i]), lat, bc, ov, qa);
      n_checks++;
      if (qa !== prev_q) begin n_fail++; $display("FAIL basic_held_q[%0d] got %0d want %0d", i, qa, prev_q); end
      n_checks++;
      if (quotient !== 8'(vq[i])) begin n_fail++; $display("FAIL basic_q[%0d] got %0d want %0d", i, quotient, vq[i]); end
      n_checks++;
      if (remainder !== 4'(vr[i])) begin n_fail++; $display("FAIL basic_r[%0d] got %0d want %0d", i, remainder, vr[i]); end
      n_checks++;
      if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz[%0d] got %0b want 0", i, div_by_zero); end
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL basic_latency[%0d] got %0d want 9", i, lat); end
      n_checks++;
      if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles[%0d] got %0d want 8", i, bc); end
      n_checks++;
      if (ov !== 0) begin n_fail++; $display("FAIL basic_busy_with_done[%0d] got %0d want 0", i, ov); end
      prev_q = 8'(vq[i]);
    end
    // done must be a single-cycle pulse
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %0b want 0", done); end
  endtask

  task automatic test_div_zero();
    int lat, bc, ov;
    logic [7:0] qa;
    run_div(8'd100, 4'd0, lat, bc, ov, qa);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_checks++;
    if (quotient !== 8'hFF) begin n_fail++; $display("FAIL dz_q got %0h want ff", quotient); end
    n_checks++;
    if (remainder !== 4'h0) begin n_fail++; $display("FAIL dz_r got %0h want 0", remainder); end
    n_checks++;
    if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %0b want 1", div_by_zero); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy got %0b want 0", busy); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dz_after done=%0b busy=%0b want 0 0", done, busy); end

    run_div(8'd100, 4'd10, lat, bc, ov, qa);
    n_checks++;
    if (qa !== 8'hFF) begin n_fail++; $display("FAIL dz_held_q got %0h want ff", qa); end
    n_checks++;
    if (quotient !== 8'd10) begin n_fail++; $display("FAIL dz_follow_q got %0d want 10", quotient); end
    n_checks++;
    if (remainder !== 4'd0) begin n_fail++; $display("FAIL dz_follow_r got %0d want 0", remainder); end
    n_checks++;
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_follow_flag got %0b want 0", div_by_zero); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL dz_follow_latency got %0d want 9", lat); end
  endtask

  task automatic test_handshake();
    int pulses;
    int done_at;
    logic drop_next;
    logic [7:0] q_seen;
    logic [3:0] r_seen;
    pulses    = 0;
    done_at   = -1;
    drop_next = 1'b0;
    q_seen    = 8'h00;
    r_seen    = 4'h0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge clk);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      dividend = 8'd60;
      divisor  = 4'd15;
      if (drop_next) begin start = 1'b0; drop_next = 1'b0; end
      if (done) begin
        pulses++;
        if (done_at < 0) done_at = k;
        q_seen    = quotient;
        r_seen    = remainder;
        drop_next = 1'b1;
      end
    end
    start = 1'b0;
    $display("handshake 200/7 with start held: q=%0d r=%0d pulses=%0d", q_seen, r_seen, pulses);
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL hs_pulses got %0d want 1", pulses); end
    n_checks++;
    if (done_at !== 8) begin n_fail++; $display("FAIL hs_done_index got %0d want 8", done_at); end
    n_checks++;
    if (q_seen !== 8'd28) begin n_fail++; $display("FAIL hs_q got %0d want 28", q_seen); end
    n_checks++;
    if (r_seen !== 4'd4) begin n_fail++; $display("FAIL hs_r got %0d want 4", r_seen); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_restart_busy got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov;
    logic [7:0] qa;
    run_div(8'd60, 4'd15, lat, bc, ov, qa);
    n_checks++;
    if (quotient !== 8'd4 || remainder !== 4'd0) begin
      n_fail++; $display("FAIL b2b_first got q=%0d r=%0d want q=4 r=0", quotient, remainder);
    end
    // run_div waits a single falling edge, so this start lands in the IDLE
    // cycle right after the done cycle.
    run_div(8'd143, 4'd11, lat, bc, ov, qa);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL b2b_latency got %0d want 9", lat); end
    n_checks++;
    if (quotient !== 8'd13 || remainder !== 4'd0) begin
      n_fail++; $display("FAIL b2b_second got q=%0d r=%0d want q=13 r=0", quotient, remainder);
    end
  endtask

  task automatic test_reset_midop();
    int lat, bc, ov;
    int pulses;
    logic [7:0] qa;
    pulses = 0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;   // between iterations 3 and 4
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (quotient !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset got q=%0d busy=%0b want q=0 busy=0", quotient, busy);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midop_no_done got %0d want 0", pulses); end
    run_div(8'd60, 4'd15, lat, bc, ov, qa);
    n_checks++;
    if (quotient !== 8'd4 || remainder !== 4'd0 || lat !== 9) begin
      n_fail++; $display("FAIL midop_next got q=%0d r=%0d lat=%0d want q=4 r=0 lat=9", quotient, remainder, lat);
    end
  endtask

  task automatic test_roundtrip();
    int lat, bc, ov;
    logic [7:0] qa;
    logic [7:0] s;
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        s = 8'(a * b);
        run_div(s, 4'(b), lat, bc, ov, qa);
        n_checks++;
        if (quotient !== 8'(a) || remainder !== 4'h0 || div_by_zero !== 1'b0 || lat !== 9) begin
          n_fail++;
          $display("FAIL roundtrip %0d/%0d got q=%0d r=%0d dbz=%0b lat=%0d want q=%0d r=0 dbz=0 lat=9",
                   s, b, quotient, remainder, div_by_zero, lat, a);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, ov;
    logic [7:0] qa;
    int a, b;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      run_div(8'(a), 4'(b), lat, bc, ov, qa);
      n_checks++;
      if (b == 0) begin
        if (quotient !== 8'hFF || remainder !== 4'h0 || div_by_zero !== 1'b1) begin
          n_fail++;
          $display("FAIL random_dz %0d/0 got q=%0d r=%0d dbz=%0b want q=255 r=0 dbz=1",
                   a, quotient, remainder, div_by_zero);
        end
      end else begin
        if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b ||
            div_by_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL random_invariant %0d/%0d got q=%0d r=%0d dbz=%0b want q*b+r=%0d r<%0d dbz=0",
                   a, b, quotient, remainder, div_by_zero, a, b);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_handshake();
    test_back_to_back();
    test_reset_midop();
    test_roundtrip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
